// File: rtl/fp_align_pkg.sv
// Shared types and sizing helpers for the floating-point operand-alignment stage.
package fp_align_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } align_state_t;

  localparam int GR_W = 2;

  // Aligned fraction keeps guard and round bits below the fraction LSB.
  function automatic int sr_width(input int frac_w);
    return frac_w + GR_W;
  endfunction

endpackage

// File: rtl/fp_mag_compare.sv
// Combinational magnitude compare of two (exponent, fraction) operands.
module fp_mag_compare #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 4
) (
  input  logic [EXP_W-1:0]  exp_a_i,
  input  logic [EXP_W-1:0]  exp_b_i,
  input  logic [FRAC_W-1:0] frac_a_i,
  input  logic [FRAC_W-1:0] frac_b_i,
  output logic              b_larger_o,
  output logic [EXP_W-1:0]  exp_diff_o
);

  logic [EXP_W:0]  ediff;
  logic [EXP_W:0]  ediff_neg;
  logic [FRAC_W:0] fdiff;

  // The extra MSB of each subtraction is the borrow, i.e. "B is larger".
  assign ediff     = {1'b0, exp_a_i} - {1'b0, exp_b_i};
  assign ediff_neg = '0 - ediff;
  assign fdiff     = {1'b0, frac_a_i} - {1'b0, frac_b_i};

  assign b_larger_o = (ediff == '0) ? fdiff[FRAC_W] : ediff[EXP_W];
  assign exp_diff_o = ediff[EXP_W] ? ediff_neg[EXP_W-1:0] : ediff[EXP_W-1:0];

endmodule

// File: rtl/fp_align_unit.sv
// Orders two operands by magnitude and right-aligns the smaller fraction one bit per cycle.
module fp_align_unit
  import fp_align_pkg::*;
#(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_W-1:0]              exp_a,
  input  logic [EXP_W-1:0]              exp_b,
  input  logic [FRAC_W-1:0]             frac_a,
  input  logic [FRAC_W-1:0]             frac_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_W-1:0]              big_exp,
  output logic [FRAC_W-1:0]             big_frac,
  output logic [sr_width(FRAC_W)-1:0]   small_frac,
  output logic                          sticky,
  output logic [EXP_W-1:0]              exp_diff,
  output logic                          swapped
);

  localparam int SR_W = sr_width(FRAC_W);

  align_state_t      state_q, state_d;
  logic [EXP_W-1:0]  ea_q, ea_d, eb_q, eb_d;
  logic [FRAC_W-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [EXP_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              sticky_q, sticky_d;
  logic              vld_q, vld_d;
  logic [EXP_W-1:0]  big_exp_q, big_exp_d;
  logic [FRAC_W-1:0] big_frac_q, big_frac_d;
  logic [EXP_W-1:0]  diff_q, diff_d;
  logic              swap_q, swap_d;

  logic              cmp_b_larger;
  logic [EXP_W-1:0]  cmp_diff;
  logic [SR_W-1:0]   sr_shr;
  logic [EXP_W-1:0]  cnt_dec;

  fp_mag_compare #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cmp (
    .exp_a_i    (ea_q),
    .exp_b_i    (eb_q),
    .frac_a_i   (fa_q),
    .frac_b_i   (fb_q),
    .b_larger_o (cmp_b_larger),
    .exp_diff_o (cmp_diff)
  );

  assign sr_shr  = sr_q >> 1;
  assign cnt_dec = cnt_q - 1'b1;

  always_comb begin
    state_d    = state_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    fa_d       = fa_q;
    fb_d       = fb_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    sticky_d   = sticky_q;
    vld_d      = vld_q;
    big_exp_d  = big_exp_q;
    big_frac_d = big_frac_q;
    diff_d     = diff_q;
    swap_d     = swap_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ea_d    = exp_a;
          eb_d    = exp_b;
          fa_d    = frac_a;
          fb_d    = frac_b;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        swap_d     = cmp_b_larger;
        big_exp_d  = cmp_b_larger ? eb_q : ea_q;
        big_frac_d = cmp_b_larger ? fb_q : fa_q;
        diff_d     = cmp_diff;
        sr_d       = {(cmp_b_larger ? fa_q : fb_q), {GR_W{1'b0}}};
        cnt_d      = cmp_diff;
        sticky_d   = 1'b0;
        if (cmp_diff == '0) begin
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d     = sr_shr;
        sticky_d = sticky_q | sr_q[0];
        cnt_d    = cnt_dec;
        // Once the register is empty, more shifts cannot change it or sticky.
        if (cnt_dec == '0 || sr_shr == '0) begin
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ea_q       <= '0;
      eb_q       <= '0;
      fa_q       <= '0;
      fb_q       <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      sticky_q   <= 1'b0;
      vld_q      <= 1'b0;
      big_exp_q  <= '0;
      big_frac_q <= '0;
      diff_q     <= '0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      sticky_q   <= sticky_d;
      vld_q      <= vld_d;
      big_exp_q  <= big_exp_d;
      big_frac_q <= big_frac_d;
      diff_q     <= diff_d;
      swap_q     <= swap_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = vld_q;
  assign big_exp    = big_exp_q;
  assign big_frac   = big_frac_q;
  assign small_frac = sr_q;
  assign sticky     = sticky_q;
  assign exp_diff   = diff_q;
  assign swapped    = swap_q;

endmodule
